cha_buf_reader: RTL and testbench

CHA_BUF_READER -- requirements
Module: cha_buf_reader

---
 rtl/cha_buf_reader_pkg.sv | 34 +++
 rtl/cha_buf_reader.sv | 115 +++++++++++
 tb/tb_cha_buf_reader.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cha_buf_reader_pkg.sv
// Shared IO/keyboard definitions for the character-buffer reader.
// Holds the buffer placement defaults, the reader FSM encoding, and the
// ASCII / scan-code constants used around the keyboard/console path.
package cha_buf_reader_pkg;

  // Buffer placement in IO word space and length in characters.
  localparam logic [15:0] CHA_BUF_START_DEF = 16'h0400;
  localparam int unsigned CHA_BUF_SIZE_DEF  = 160;

  // Reader FSM states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_PRESENT = 2'd3
  } rd_state_t;

  // ASCII constants.
  localparam logic [7:0] ASCII_NUL = 8'h00;
  localparam logic [7:0] ASCII_BS  = 8'h08;
  localparam logic [7:0] ASCII_LF  = 8'h0A;
  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_ESC = 8'h1B;
  localparam logic [7:0] ASCII_SP  = 8'h20;

  // PS/2 set-2 scan codes.
  localparam logic [7:0] SC_BREAK    = 8'hF0;
  localparam logic [7:0] SC_EXTENDED = 8'hE0;
  localparam logic [7:0] SC_ENTER    = 8'h5A;
  localparam logic [7:0] SC_BKSP     = 8'h66;
  localparam logic [7:0] SC_ESC      = 8'h76;
  localparam logic [7:0] SC_SPACE    = 8'h29;

endpackage

// File: rtl/cha_buf_reader.sv
// Character-buffer reader.
// Drains characters from a circular buffer of packed 16-bit IO words
// (two characters per word, even index in the high byte) and presents
// them one at a time on a valid/ready interface.
// Ports:
//   CLK, RST        - clock, synchronous active-high reset
//   WR_PTR          - writer's next character index
//   FLUSH           - drop all unread characters (RD_PTR <= WR_PTR)
//   RADDR_IO        - IO read word address (held outside FETCH)
//   RD_IO_ON        - IO read strobe, high only in FETCH
//   DATA_OUT_IO     - IO read data, valid the cycle after RD_IO_ON
//   ASCII           - presented character
//   ASCII_VALID     - ASCII holds a character
//   ASCII_READY     - consumer accepts ASCII
//   RD_PTR          - next character index to read
module cha_buf_reader
  import cha_buf_reader_pkg::*;
#(
  parameter logic [15:0] CHA_BUF_START = CHA_BUF_START_DEF,
  parameter int unsigned CHA_BUF_SIZE  = CHA_BUF_SIZE_DEF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] WR_PTR,
  input  logic        FLUSH,
  output logic [15:0] RADDR_IO,
  output logic        RD_IO_ON,
  input  logic [15:0] DATA_OUT_IO,
  output logic [7:0]  ASCII,
  output logic        ASCII_VALID,
  input  logic        ASCII_READY,
  output logic [15:0] RD_PTR
);

  localparam logic [15:0] SIZE_W = 16'(CHA_BUF_SIZE);
  localparam logic [15:0] LAST_W = 16'(CHA_BUF_SIZE - 1);

  rd_state_t   state_q, state_d;
  logic [15:0] rd_ptr_q, rd_ptr_d;
  logic [15:0] raddr_q, raddr_d;
  logic [7:0]  ascii_q, ascii_d;

  logic        empty;
  logic [15:0] ptr_next;
  logic [15:0] fetch_addr;
  logic [7:0]  cap_byte;

  // An out-of-range writer pointer is treated as an empty buffer.
  assign empty      = (rd_ptr_q == WR_PTR) || (WR_PTR >= SIZE_W);
  assign ptr_next   = (rd_ptr_q == LAST_W) ? '0 : rd_ptr_q + 16'd1;
  assign fetch_addr = CHA_BUF_START + {1'b0, rd_ptr_q[15:1]};
  assign cap_byte   = rd_ptr_q[0] ? DATA_OUT_IO[7:0] : DATA_OUT_IO[15:8];

  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    raddr_d  = raddr_q;
    ascii_d  = ascii_q;
    case (state_q)
      ST_IDLE: begin
        // Address is latched on entry to FETCH so it is stable during the
        // strobe and simply holds afterwards.
        if (!empty && !FLUSH) begin
          state_d = ST_FETCH;
          raddr_d = fetch_addr;
        end
      end
      ST_FETCH: state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        // NUL marks an unwritten slot: consume it silently.
        if (cap_byte != ASCII_NUL) begin
          ascii_d = cap_byte;
          state_d = ST_PRESENT;
        end else begin
          rd_ptr_d = ptr_next;
          state_d  = ST_IDLE;
        end
      end
      ST_PRESENT: begin
        if (ASCII_READY) begin
          rd_ptr_d = ptr_next;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Flush overrides everything, including a same-cycle handshake and
    // an in-flight read whose data is then never captured.
    if (FLUSH) begin
      rd_ptr_d = WR_PTR;
      state_d  = ST_IDLE;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      rd_ptr_q <= '0;
      raddr_q  <= '0;
      ascii_q  <= '0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      raddr_q  <= raddr_d;
      ascii_q  <= ascii_d;
    end
  end

  assign RADDR_IO    = raddr_q;
  assign RD_IO_ON    = (state_q == ST_FETCH);
  assign ASCII       = ascii_q;
  assign ASCII_VALID = (state_q == ST_PRESENT);
  assign RD_PTR      = rd_ptr_q;

endmodule

// File: tb/tb_cha_buf_reader.sv
// Directed bench for cha_buf_reader: a small IO word memory answers reads
// one cycle after the strobe; hand-written sequences cover latency, hold,
// flush and reset corners, and a vector table covers single-read cases.
module tb_cha_buf_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] wr_ptr;
  logic        flush;
  logic [15:0] raddr_io;
  logic        rd_io_on;
  logic [15:0] data_out_io;
  logic [7:0]  ascii;
  logic        ascii_valid;
  logic        ascii_ready;
  logic [15:0] rd_ptr;

  int tests = 0;
  int fails = 0;

  logic [15:0] mem [0:79];

  cha_buf_reader #(
    .CHA_BUF_START(16'h0400),
    .CHA_BUF_SIZE (160)
  ) dut (
    .CLK        (clk),
    .RST        (rst),
    .WR_PTR     (wr_ptr),
    .FLUSH      (flush),
    .RADDR_IO   (raddr_io),
    .RD_IO_ON   (rd_io_on),
    .DATA_OUT_IO(data_out_io),
    .ASCII      (ascii),
    .ASCII_VALID(ascii_valid),
    .ASCII_READY(ascii_ready),
    .RD_PTR     (rd_ptr)
  );

  always #5 clk = ~clk;

  // IO memory: data returned the cycle after the strobe, junk otherwise.
  always @(posedge clk) begin
    logic [15:0] idx;
    idx = raddr_io - 16'h0400;
    if (rd_io_on) data_out_io <= (idx < 16'd80) ? mem[idx] : 16'hFFFF;
    else          data_out_io <= 16'hA5A5;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_valid(input string name, input int max_cycles);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (ascii_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk(name, {31'd0, seen}, 32'd1);
  endtask

  typedef struct {
    logic [15:0] start;
    logic [15:0] wr;
    int          widx;
    logic [15:0] word;
    int          exp_fetch;
    int          exp_emit;
    logic [7:0]  exp_ch;
    logic [15:0] exp_addr;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int          io_cnt, first_io, first_val, emit;
    logic [7:0]  chs [2];
    logic [15:0] last_addr;
    bit          stable;

    for (int i = 0; i < 80; i++) mem[i] = 16'h0000;
    data_out_io = 16'hA5A5;
    vecs[0] = '{16'd0,   16'd1,   0,  16'h4142, 1, 1, 8'h41, 16'h0400, 16'd1};
    vecs[1] = '{16'd1,   16'd2,   0,  16'h4142, 1, 1, 8'h42, 16'h0400, 16'd2};
    vecs[2] = '{16'd159, 16'd0,   79, 16'h007A, 1, 1, 8'h7A, 16'h044F, 16'd0};
    vecs[3] = '{16'd0,   16'd2,   0,  16'h0043, 2, 1, 8'h43, 16'h0400, 16'd2};
    vecs[4] = '{16'd2,   16'd3,   1,  16'h6162, 1, 1, 8'h61, 16'h0401, 16'd3};
    vecs[5] = '{16'd158, 16'd159, 79, 16'h5A00, 1, 1, 8'h5A, 16'h044F, 16'd159};
    vecs[6] = '{16'd159, 16'd0,   79, 16'h5A00, 1, 0, 8'h00, 16'h044F, 16'd0};
    vecs[7] = '{16'd5,   16'd200, 2,  16'h4141, 0, 0, 8'h00, 16'h0000, 16'd5};

    // Reset state, then idle with an empty buffer.
    rst = 1'b1; wr_ptr = 16'd0; flush = 1'b0; ascii_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rd_ptr", {16'd0, rd_ptr}, 32'd0);
    chk("rst_valid", {31'd0, ascii_valid}, 32'd0);
    chk("rst_rd_io_on", {31'd0, rd_io_on}, 32'd0);
    chk("rst_raddr", {16'd0, raddr_io}, 32'd0);
    chk("rst_ascii", {24'd0, ascii}, 32'd0);
    rst = 1'b0;
    io_cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (rd_io_on) io_cnt++;
    end
    chk("empty_no_strobe", io_cnt, 0);

    // Two characters from one word, with latency measured from the
    // first IDLE cycle that sees the buffer non-empty (k = 0).
    mem[0] = 16'h4142;
    ascii_ready = 1'b1;
    @(posedge clk); #1 wr_ptr = 16'd2;
    io_cnt = 0; first_io = -1; first_val = -1; emit = 0; last_addr = '0;
    stable = 1'b1;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (rd_io_on) begin
        io_cnt++;
        if (first_io < 0) first_io = k;
        if (raddr_io != 16'h0400) stable = 1'b0;
      end
      if (ascii_valid) begin
        if (first_val < 0) first_val = k;
        if (emit < 2) chs[emit] = ascii;
        emit++;
      end
    end
    chk("lat_first_strobe", first_io, 1);
    chk("lat_first_valid", first_val, 3);
    chk("lat_fetch_count", io_cnt, 2);
    chk("lat_fetch_addr", {31'd0, stable}, 32'd1);
    chk("lat_emit_count", emit, 2);
    chk("lat_char0", {24'd0, chs[0]}, 32'h41);
    chk("lat_char1", {24'd0, chs[1]}, 32'h42);
    chk("lat_rd_ptr", {16'd0, rd_ptr}, 32'd2);

    // Consumer stalls for 10 cycles, then a flush drops the character.
    mem[1] = 16'h4344;
    ascii_ready = 1'b0;
    wr_ptr = 16'd3;
    wait_valid("hold_reach_valid", 10);
    stable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!ascii_valid || ascii != 8'h43) stable = 1'b0;
    end
    chk("hold_stable", {31'd0, stable}, 32'd1);
    flush = 1'b1; wr_ptr = 16'd7;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_valid", {31'd0, ascii_valid}, 32'd0);
    chk("flush_rd_ptr", {16'd0, rd_ptr}, 32'd7);

    // Flush coinciding with a handshake: pointer takes WR_PTR, no advance.
    mem[3] = 16'h4A4B;
    wr_ptr = 16'd8;
    wait_valid("fh_reach_valid", 10);
    chk("fh_ascii", {24'd0, ascii}, 32'h4B);
    ascii_ready = 1'b1; flush = 1'b1; wr_ptr = 16'd20;
    @(posedge clk); #1 flush = 1'b0; ascii_ready = 1'b0;
    @(negedge clk);
    chk("fh_valid", {31'd0, ascii_valid}, 32'd0);
    chk("fh_rd_ptr", {16'd0, rd_ptr}, 32'd20);

    // Flush during FETCH: the returning word must be ignored.
    mem[10] = 16'h4D4E;
    ascii_ready = 1'b1;
    @(posedge clk); #1 wr_ptr = 16'd21;
    @(negedge clk);
    @(negedge clk);
    chk("ff_in_fetch", {31'd0, rd_io_on}, 32'd1);
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    emit = 0;
    repeat (6) begin
      @(negedge clk);
      if (ascii_valid) emit++;
    end
    chk("ff_no_valid", emit, 0);
    chk("ff_rd_ptr", {16'd0, rd_ptr}, 32'd21);

    // Reset in CAPTURE, with FLUSH also high: reset wins.
    @(posedge clk); #1 wr_ptr = 16'd22;
    @(negedge clk);
    @(negedge clk);
    chk("rc_in_fetch", {31'd0, rd_io_on}, 32'd1);
    @(negedge clk);
    rst = 1'b1; flush = 1'b1;
    @(posedge clk); #1 rst = 1'b0; flush = 1'b0; wr_ptr = 16'd0;
    chk("rc_rd_ptr", {16'd0, rd_ptr}, 32'd0);
    chk("rc_valid", {31'd0, ascii_valid}, 32'd0);
    chk("rc_raddr", {16'd0, raddr_io}, 32'd0);
    chk("rc_ascii", {24'd0, ascii}, 32'd0);
    emit = 0;
    repeat (5) begin
      @(negedge clk);
      if (ascii_valid) emit++;
    end
    chk("rc_no_valid", emit, 0);

    // Single-read vectors.
    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      flush = 1'b1; wr_ptr = vecs[v].start; ascii_ready = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
      mem[vecs[v].widx] = vecs[v].word;
      wr_ptr = vecs[v].wr;
      io_cnt = 0; emit = 0; last_addr = '0; chs[0] = '0;
      for (int k = 0; k < 14; k++) begin
        @(negedge clk);
        if (rd_io_on) begin
          io_cnt++;
          last_addr = raddr_io;
        end
        if (ascii_valid) begin
          if (emit == 0) chs[0] = ascii;
          emit++;
        end
      end
      chk($sformatf("vec%0d_fetch", v), io_cnt, vecs[v].exp_fetch);
      chk($sformatf("vec%0d_emit", v), emit, vecs[v].exp_emit);
      if (vecs[v].exp_emit > 0)
        chk($sformatf("vec%0d_char", v), {24'd0, chs[0]}, {24'd0, vecs[v].exp_ch});
      if (vecs[v].exp_fetch > 0)
        chk($sformatf("vec%0d_addr", v), {16'd0, last_addr}, {16'd0, vecs[v].exp_addr});
      chk($sformatf("vec%0d_rd_ptr", v), {16'd0, rd_ptr}, {16'd0, vecs[v].exp_rd});
      mem[vecs[v].widx] = 16'h0000;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
